prog_ram_loader_64b: RTL and testbench
======================================

# prog_ram_loader_64B

Writable 64-byte program store that replaces the fixed program ROM in front of the minibyte CPU fetch path. An external byte-stream loader writes the program through a valid/ready port while the CPU is held in halt. Once loading completes, the CPU is released and reads the store through the same combinational address/data interface the ROM presents. A later load request re-halts the CPU and overwrites the store.

## Interface
- DEPTH, 64, number of bytes in the store
- ADDR_W, 6, address width, log2(DEPTH)
- DATA_W, 8, byte width
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- load_req  input  1  level request to enter load mode
- ld_valid  input  1  loader byte valid
- ld_data  input  DATA_W  loader byte
- ld_last  input  1  marks final byte of the stream; qualified by ld_valid
- ld_ready  output  1  store accepts a byte this cycle
- address  input  ADDR_W  CPU fetch/read address
- data_out  output  DATA_W  mem[address], combinational
- cpu_halt  output  1  holds the CPU; high whenever the state is not RUN
- load_done  output  1  high in RUN
- byte_count  output  ADDR_W+1  bytes accepted in the current or last load, 0..64

## Operation
- Storage: DEPTH x DATA_W flops plus wr_ptr (ADDR_W+1 bits). On reset, every byte is cleared to 0x00, which is the NOP opcode.
- States: IDLE, LOADING, RUN. Reset state is IDLE.
- IDLE:
  - cpu_halt=1, ld_ready=0.
  - If load_req=1, go to LOADING and clear wr_ptr and byte_count.
  - If load_req=0, go to RUN. The CPU then executes the current contents.
- LOADING:
  - ld_ready=1, cpu_halt=1.
  - Transfer condition: ld_valid & ld_ready. On a transfer, write mem[wr_ptr[ADDR_W-1:0]] <= ld_data and increment wr_ptr and byte_count.
  - Go to RUN on a transfer with ld_last=1, or on the transfer of the DEPTH-th byte (wr_ptr=63), whichever comes first.
  - Bytes not written keep their prior contents.
  - load_req is ignored while in LOADING.
- RUN:
  - cpu_halt=0, ld_ready=0, load_done=1. byte_count holds its final value.
  - load_req=1 returns the block to LOADING and clears wr_ptr and byte_count.
- ld_valid in IDLE or RUN: ignored, no write. The loader must hold ld_data until ld_ready is seen.
- data_out always reflects the current contents, including during LOADING. A byte written at edge k is visible on data_out after edge k.
- Outputs ld_ready, cpu_halt and load_done are decoded from the registered state only; none depends combinationally on inputs.

## Timing
- Reset values: state=IDLE, cpu_halt=1, ld_ready=0, load_done=0, byte_count=0, all memory 0x00, data_out=0x00.
- IDLE exits after exactly one cycle, since either transition is taken at the first edge after rst_n deasserts.
- LOADING entry: load_req sampled high at edge k gives ld_ready=1 and cpu_halt=1 from edge k to edge k+1 onward.
- Throughput: one byte per cycle while ld_valid is held high. N bytes take N cycles.
- Exit: final transfer at edge k gives cpu_halt=0, ld_ready=0, load_done=1 immediately after edge k. No byte is accepted after the final one.
- Overflow: wrap is impossible. The 64th transfer forces RUN even if ld_last=0.
- ld_last on the first byte gives a 1-byte load: byte_count=1.
- Asynchronous reset mid-load: the store is immediately re-cleared, the state goes to IDLE and cpu_halt=1. A partial load is not preserved.
- No read latency on the CPU side: data_out is combinational from address, matching the ROM timing the CPU expects.

## Test plan
- **Reset:** assert rst_n=0 with random address.
  - During reset: data_out=0x00, cpu_halt=1, ld_ready=0, load_done=0, byte_count=0.
  - Release with load_req=0: RUN one edge later, cpu_halt=0.
- **Short load:** load_req=1; stream 0x00,0x01,0x00,0x05,0x01 back-to-back with ld_last on the 5th byte.
  - After the 5th edge: cpu_halt=0, byte_count=5.
  - address 3 -> 0x05; address 5 -> 0x00 (unwritten).
- **Backpressure/gaps:** toggle ld_valid randomly over 10 bytes.
  - Exactly 10 writes at the correct addresses, no duplicate or skipped bytes, byte_count=10.
- **Full load:** 64 bytes, value = address XOR 0xA5, ld_last never asserted.
  - RUN after the 64th transfer, byte_count=64, ld_ready=0.
  - A 65th valid byte does not overwrite address 0.
- **Reload from RUN:** after a load of 0x11 at address 0, assert load_req, then load 0x22 at address 0 with ld_last.
  - cpu_halt high from the edge after load_req.
  - address 0 -> 0x22; address 1 still holds its old value.
- **Reset mid-load:** pulse rst_n low after 3 of 8 bytes.
  - Immediately: all addresses read 0x00, state IDLE, byte_count=0, ld_ready=0.

Source files
------------

// File: rtl/prog_ram_loader_64b.sv
// Writable 64-byte program store with a valid/ready byte loader in front of the CPU fetch path.
// The CPU is held in halt while loading and reads the store combinationally, like the ROM it replaces.
module prog_ram_loader_64b #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              cpu_halt,
  output logic              load_done,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    RUN
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic              xfer;
  logic              last_xfer;
  logic              clear_ptr;

  assign ld_ready  = (state == LOADING);
  assign cpu_halt  = (state != RUN);
  assign load_done = (state == RUN);
  assign xfer      = ld_valid & ld_ready;
  // The DEPTH-th byte ends the load even without ld_last, so wr_ptr can never wrap.
  assign last_xfer = xfer & (ld_last | (wr_ptr == (ADDR_W+1)'(DEPTH - 1)));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    clear_ptr = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) begin
          state_nxt = LOADING;
          clear_ptr = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      LOADING: begin
        if (last_xfer) state_nxt = RUN;
      end
      RUN: begin
        if (load_req) begin
          state_nxt = LOADING;
          clear_ptr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wr_ptr <= '0;
    else if (clear_ptr) wr_ptr <= '0;
    else if (xfer)      wr_ptr <= wr_ptr + 1'b1;
  end

  // NOTE: the store is a flop array, not an SRAM macro, so it can take the async reset to NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (xfer) begin
      mem[wr_ptr[ADDR_W-1:0]] <= ld_data;
    end
  end

  assign byte_count = wr_ptr;
  assign data_out   = mem[address];

endmodule

// File: tb/tb_prog_ram_loader_64b.sv
// Self-checking bench for prog_ram_loader_64b: directed tables plus randomized loads
// compared against a byte-array model of the store.
module tb_prog_ram_loader_64b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_req;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic [5:0] address;
  logic [7:0] data_out;
  logic       cpu_halt;
  logic       load_done;
  logic [6:0] byte_count;

  prog_ram_loader_64b dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .address    (address),
    .data_out   (data_out),
    .cpu_halt   (cpu_halt),
    .load_done  (load_done),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] ref_mem [64];
  int         ref_cnt;
  logic [7:0] stim [80];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    ref_cnt = 0;
  endtask

  task automatic dump_check(input string name);
    for (int a = 0; a < 64; a++) begin
      address = 6'(a);
      #1;
      check(name, data_out, ref_mem[a]);
    end
  endtask

  // Load stim[0..] from RUN; the model accepts a byte whenever the loader offers one during
  // load mode and leaves load mode on ld_last or after the 64th byte.
  task automatic run_load(input int n, input int last_idx, input bit gaps);
    int idx = 0;
    int cyc = 0;
    bit in_load = 1'b1;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    check("enter_ready", ld_ready, 1);
    check("enter_halt", cpu_halt, 1);
    check("enter_count", byte_count, 0);
    ref_cnt = 0;
    while (in_load && idx < n) begin
      if (cyc >= 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL load_timeout: got %0d bytes expected %0d", idx, n);
        break;
      end
      ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = stim[idx];
      ld_last  = (idx == last_idx);
      step();
      cyc++;
      if (ld_valid) begin
        ref_mem[ref_cnt] = stim[idx];
        ref_cnt++;
        if (idx == last_idx || ref_cnt == 64) in_load = 1'b0;
        idx++;
        address = 6'(ref_cnt - 1);
        #1;
        check("ld_visible", data_out, ref_mem[ref_cnt-1]);
      end
      check("ld_count", byte_count, ref_cnt);
      check("ld_halt", cpu_halt, in_load);
      check("ld_ready", ld_ready, in_load);
      check("ld_done", load_done, !in_load);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  rd_vec_t    short_tbl [6];
  logic [7:0] old1;

  initial begin
    short_tbl[0] = '{6'd0, 8'h00};
    short_tbl[1] = '{6'd1, 8'h01};
    short_tbl[2] = '{6'd2, 8'h00};
    short_tbl[3] = '{6'd3, 8'h05};
    short_tbl[4] = '{6'd4, 8'h01};
    short_tbl[5] = '{6'd5, 8'h00};

    rst_n    = 1'b0;
    load_req = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    ld_last  = 1'b0;
    address  = 6'($urandom_range(0, 63));
    clear_model();
    #1;
    check("rst_data", data_out, 8'h00);
    check("rst_halt", cpu_halt, 1);
    check("rst_ready", ld_ready, 0);
    check("rst_done", load_done, 0);
    check("rst_count", byte_count, 0);

    // Release with load_req low: one IDLE cycle, then RUN.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_halt", cpu_halt, 1);
    step();
    check("run_halt", cpu_halt, 0);
    check("run_done", load_done, 1);
    check("run_count", byte_count, 0);

    // Short load with ld_last on the 5th byte.
    stim[0] = 8'h00; stim[1] = 8'h01; stim[2] = 8'h00; stim[3] = 8'h05; stim[4] = 8'h01;
    run_load(5, 4, 1'b0);
    check("short_halt", cpu_halt, 0);
    check("short_count", byte_count, 5);
    for (int i = 0; i < 6; i++) begin
      address = short_tbl[i].addr;
      #1;
      check("short_read", data_out, short_tbl[i].exp);
    end

    // Ten bytes with random gaps on ld_valid.
    for (int i = 0; i < 10; i++) stim[i] = 8'($urandom);
    run_load(10, 9, 1'b1);
    check("gap_count", byte_count, 10);
    dump_check("gap_mem");

    // Full load without ld_last; a 65th byte must be ignored.
    for (int i = 0; i < 64; i++) stim[i] = 8'(i) ^ 8'hA5;
    run_load(64, -1, 1'b0);
    check("full_count", byte_count, 64);
    check("full_ready", ld_ready, 0);
    ld_valid = 1'b1;
    ld_data  = 8'hFF;
    ld_last  = 1'b1;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    address  = 6'd0;
    #1;
    check("full_no_65th", data_out, 8'hA5);
    check("full_count_hold", byte_count, 64);
    dump_check("full_mem");

    // Reload from RUN.
    stim[0] = 8'h11;
    run_load(1, 0, 1'b0);
    check("one_byte_count", byte_count, 1);
    old1 = ref_mem[1];
    stim[0] = 8'h22;
    run_load(1, 0, 1'b0);
    address = 6'd0;
    #1;
    check("reload_a0", data_out, 8'h22);
    address = 6'd1;
    #1;
    check("reload_a1", data_out, old1);

    // Random-length loads with random gaps.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 64);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      run_load(n, (n == 64 && r[0]) ? -1 : n - 1, 1'($urandom_range(0, 1)));
      check("rand_count", byte_count, n);
      dump_check("rand_mem");
    end

    // Asynchronous reset after 3 of 8 bytes.
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom_range(1, 255));
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = stim[i];
      step();
    end
    check("mid_count3", byte_count, 3);
    ld_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    clear_model();
    check("mid_halt", cpu_halt, 1);
    check("mid_ready", ld_ready, 0);
    check("mid_count", byte_count, 0);
    check("mid_done", load_done, 0);
    dump_check("mid_mem");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mid_run", load_done, 1);
    check("mid_run_count", byte_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
